// File: rtl/rom_scan_ctrl.sv
// Sequencer for the 8x8 ROM: reads a wrap-around run of words, hands each one
// downstream over valid/ready, and keeps a running sum and maximum per run.
module rom_scan_ctrl #(
  parameter int DW = 8,
  parameter int AW = 3,
  parameter int SW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   count,
  output logic          rom_cs,
  output logic          rom_read_en,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] sum,
  output logic [DW-1:0] max_val
);

  typedef enum logic [1:0] {IDLE, FETCH, OUT, DONE} state_t;

  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   rem_q, rem_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [DW-1:0] max_q, max_d;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    sum_d      = sum_q;
    max_d      = max_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = start_addr;
          rem_d   = (count > DEPTH) ? DEPTH : count;
          sum_d   = '0;
          max_d   = '0;
          state_d = (count == '0) ? DONE : FETCH;
        end
      end
      // rom_data is only sampled here, the one state where the ROM is selected
      FETCH: begin
        out_data_d = rom_data;
        out_addr_d = addr_q;
        sum_d      = sum_q + SW'(rom_data);
        max_d      = (rom_data > max_q) ? rom_data : max_q;
        state_d    = OUT;
      end
      OUT: begin
        if (out_ready) begin
          rem_d   = rem_q - 1'b1;
          addr_d  = addr_q + 1'b1;
          state_d = (rem_q == (AW+1)'(1)) ? DONE : FETCH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      out_data_q <= '0;
      out_addr_q <= '0;
      sum_q      <= '0;
      max_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      out_data_q <= out_data_d;
      out_addr_q <= out_addr_d;
      sum_q      <= sum_d;
      max_q      <= max_d;
    end
  end

  // Control outputs decode straight from the registered state, so none depend on out_ready.
  assign rom_cs      = (state_q == FETCH);
  assign rom_read_en = (state_q == FETCH);
  assign rom_addr    = addr_q;
  assign out_data    = out_data_q;
  assign out_addr    = out_addr_q;
  assign out_valid   = (state_q == OUT);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign sum         = sum_q;
  assign max_val     = max_q;

endmodule

// File: doc/rom_scan_ctrl.md
Name: rom_scan_ctrl

Overview:
- Sequencer that sits directly upstream of the 8x8 ROM and drives its chip-select, read-enable and address.
- On a start command it reads a contiguous, wrap-around run of ROM words, one per read cycle, and captures each word into a register.
- Each captured word, with its address, goes downstream over a valid/ready handshake.
- Accumulates a running sum and maximum of the words read, and pulses done at the end of the run.

Parameters:
- DW, 8, ROM data width.
- AW, 3, ROM address width; depth = 2**AW = 8.
- SW, 11, sum width; holds 8 x 255 = 2040 without overflow.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- start_addr  in  AW  first ROM address of the run.
- count  in  AW+1  words to read; 0 = empty run; values >8 saturate to 8.
- rom_cs  out  1  ROM chip select.
- rom_read_en  out  1  ROM read enable.
- rom_addr  out  AW  ROM address.
- rom_data  in  DW  ROM data. Combinational from address; high-Z when not selected.
- out_data  out  DW  captured ROM word.
- out_addr  out  AW  address the word came from.
- out_valid  out  1  out_data/out_addr valid.
- out_ready  in  1  downstream accepts the word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run.
- sum  out  SW  unsigned sum of words read this run.
- max_val  out  DW  largest word read this run.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state = IDLE.
  - All outputs 0: rom_cs, rom_read_en, rom_addr, out_data, out_addr, out_valid, busy, done, sum, max_val.
  - Reset mid-run aborts immediately. No done pulse and no further ROM access.
- States: IDLE, FETCH, OUT, DONE.
- IDLE:
  - rom_cs = rom_read_en = 0.
  - On start=1:
    - Latch addr_reg = start_addr and rem = min(count, 8).
    - Clear sum and max_val.
    - If rem = 0, go to DONE; otherwise go to FETCH.
- FETCH (exactly 1 cycle):
  - rom_cs = rom_read_en = 1; rom_addr = addr_reg.
  - At the clock edge:
    - out_data <= rom_data; out_addr <= addr_reg.
    - sum <= sum + rom_data, zero-extended to SW.
    - max_val <= max(max_val, rom_data), unsigned compare.
  - Go to OUT.
- OUT:
  - rom_cs = rom_read_en = 0; out_valid = 1.
  - out_data and out_addr are held stable while out_ready = 0, for any number of cycles.
  - On out_valid & out_ready:
    - rem <= rem - 1; addr_reg <= addr_reg + 1, mod 8 (7 wraps to 0).
    - If rem = 1, go to DONE; otherwise go to FETCH.
- DONE:
  - done = 1 for one cycle; busy still 1.
  - Go to IDLE.
- rom_addr always equals addr_reg. The ROM is never enabled outside FETCH, so rom_data is never sampled while high-Z.
- sum and max_val hold their final values in IDLE until the next accepted start.
- start while busy is ignored, with no effect on the current run.
- Timing:
  - Throughput with out_ready tied high: 2 cycles per word.
  - Run of n words: the start edge, n FETCH + n OUT cycles, and 1 DONE cycle.
- out_valid never depends combinationally on out_ready. All outputs are registered or decoded from state.

Test Plan:
- Full scan:
  - Stimulus: ROM contents 2e,38,4c,58,68,7f,88,9a; start_addr=0, count=8, out_ready=1.
  - Response: out_data sequence 2e..9a with out_addr 0..7; done pulses once; sum=0x313; max_val=0x9a; 16 cycles from FETCH entry to DONE.
- Wrap-around:
  - Stimulus: start_addr=6, count=3.
  - Response: words 88(addr 6), 9a(addr 7), 2e(addr 0); sum=0x150; max_val=0x9a.
- Backpressure:
  - Stimulus: start_addr=2, count=2; out_ready low 5 cycles on each word.
  - Response: out_data=4c held for all 5 cycles, then 58; rom_cs=0 throughout OUT; sum=0x0a4; max_val=0x58.
- Empty and oversize:
  - count=0: no rom_cs assertion; done 1 cycle after start is sampled; sum=0; max_val=0.
  - count=12: exactly 8 words read.
- Start while busy:
  - Stimulus: pulse start again mid-run with different start_addr.
  - Response: ignored; original sequence and sum unchanged.
- Reset mid-run:
  - Stimulus: assert rst during the third OUT of a full scan.
  - Response: next cycle all outputs 0, state IDLE, no done; a fresh start then completes normally.
